// File: rtl/mito_pkg.sv
// Shared definitions for the layer parameter loader: demux select codes and
// load sequencing states.
package mito_pkg;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_IFM  = 2'b01;
  localparam logic [1:0] SEL_WGT  = 2'b10;
  localparam logic [1:0] SEL_BIAS = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IFM,
    LOAD_WGT,
    LOAD_BIAS,
    FINISH
  } load_state_e;

  function automatic logic [1:0] phase_sel(input load_state_e st);
    logic [1:0] code;
    code = SEL_NONE;
    unique case (st)
      LOAD_IFM:  code = SEL_IFM;
      LOAD_WGT:  code = SEL_WGT;
      LOAD_BIAS: code = SEL_BIAS;
      default:   code = SEL_NONE;
    endcase
    return code;
  endfunction

  // First non-empty phase strictly after cur; FINISH when none remain.
  function automatic load_state_e next_phase(input load_state_e cur, input logic has_ifm,
                                             input logic has_wgt, input logic has_bias);
    load_state_e nxt;
    nxt = FINISH;
    if (cur == IDLE && has_ifm) begin
      nxt = LOAD_IFM;
    end else if ((cur == IDLE || cur == LOAD_IFM) && has_wgt) begin
      nxt = LOAD_WGT;
    end else if ((cur == IDLE || cur == LOAD_IFM || cur == LOAD_WGT) && has_bias) begin
      nxt = LOAD_BIAS;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/load_addr_counter.sv
// Per-phase write address counter with terminal-count detect against the
// latched phase length.
module load_addr_counter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              incr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] count_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (incr_i) begin
      count_d = count_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // A zero length never matches: len-1 wraps above any reachable count.
  assign last_o  = (LEN_W'(count_q) == (len_i - LEN_W'(1)));

endmodule

// File: rtl/buffer_load_sequencer.sv
// Streams one layer's IFM, weight and bias words into their buffers as three
// contiguous bursts through a shared demux, write strobe and address.
module buffer_load_sequencer
  import mito_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned LEN_W      = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      cfg_ifm_len,
  input  logic [LEN_W-1:0]      cfg_wgt_len,
  input  logic [LEN_W-1:0]      cfg_bias_len,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [1:0]            sel,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned MaxLen = 1 << ADDR_W;

  load_state_e           state_q, state_d;
  logic [LEN_W-1:0]      ifm_len_q, ifm_len_d;
  logic [LEN_W-1:0]      wgt_len_q, wgt_len_d;
  logic [LEN_W-1:0]      bias_len_q, bias_len_d;
  logic                  drain_q, drain_d;
  logic [1:0]            sel_q, sel_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;

  logic                  in_load;
  logic                  accept;
  logic                  cnt_clear, cnt_incr, cnt_last;
  logic [ADDR_W-1:0]     cnt;
  logic [LEN_W-1:0]      cur_len;
  load_state_e           after_phase;

  assign in_load  = (state_q == LOAD_IFM) || (state_q == LOAD_WGT) || (state_q == LOAD_BIAS);
  // drain_q marks the cycle the final word is being written; no more accepts.
  assign in_ready = in_load && !drain_q;
  assign accept   = in_valid && in_ready;
  assign busy     = in_load;
  assign done     = (state_q == FINISH);

  always_comb begin
    cur_len = '0;
    unique case (state_q)
      LOAD_IFM:  cur_len = ifm_len_q;
      LOAD_WGT:  cur_len = wgt_len_q;
      LOAD_BIAS: cur_len = bias_len_q;
      default:   cur_len = '0;
    endcase
  end

  assign after_phase = next_phase(state_q, 1'b0, (wgt_len_q != '0), (bias_len_q != '0));

  load_addr_counter #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (cnt_clear),
    .incr_i  (cnt_incr),
    .len_i   (cur_len),
    .count_o (cnt),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    ifm_len_d  = ifm_len_q;
    wgt_len_d  = wgt_len_q;
    bias_len_d = bias_len_q;
    drain_d    = drain_q;
    sel_d      = sel_q;
    out_data_d = out_data_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    cnt_clear  = 1'b0;
    cnt_incr   = 1'b0;

    unique case (state_q)
      IDLE: begin
        sel_d = SEL_NONE;
        if (start) begin
          ifm_len_d  = cfg_ifm_len;
          wgt_len_d  = cfg_wgt_len;
          bias_len_d = cfg_bias_len;
          cnt_clear  = 1'b1;
          state_d    = next_phase(IDLE, (cfg_ifm_len != '0), (cfg_wgt_len != '0),
                                  (cfg_bias_len != '0));
        end
      end
      LOAD_IFM, LOAD_WGT, LOAD_BIAS: begin
        if (drain_q) begin
          drain_d = 1'b0;
          state_d = FINISH;
        end else if (accept) begin
          wr_en_d    = 1'b1;
          out_data_d = in_data;
          sel_d      = phase_sel(state_q);
          wr_addr_d  = cnt;
          if (cnt_last) begin
            cnt_clear = 1'b1;
            if (after_phase == FINISH) begin
              drain_d = 1'b1;
            end else begin
              state_d = after_phase;
            end
          end else begin
            cnt_incr = 1'b1;
          end
        end
      end
      FINISH: begin
        sel_d   = SEL_NONE;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ifm_len_q  <= '0;
      wgt_len_q  <= '0;
      bias_len_q <= '0;
      drain_q    <= 1'b0;
      sel_q      <= SEL_NONE;
      out_data_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      ifm_len_q  <= ifm_len_d;
      wgt_len_q  <= wgt_len_d;
      bias_len_q <= bias_len_d;
      drain_q    <= drain_d;
      sel_q      <= sel_d;
      out_data_q <= out_data_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  assign sel      = sel_q;
  assign out_data = out_data_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;

  cfg_len_legal: assert property (@(posedge clk) disable iff (!rst_n)
      (start && state_q == IDLE) |-> (32'(cfg_ifm_len) <= MaxLen &&
                                      32'(cfg_wgt_len) <= MaxLen &&
                                      32'(cfg_bias_len) <= MaxLen));

endmodule

// File: tb/tb_buffer_load_sequencer.sv
// Self-checking bench for buffer_load_sequencer: table of directed loads plus
// randomized loads, all checked cycle by cycle against a word-list model.
module tb_buffer_load_sequencer;
  import mito_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] cfg_ifm_len = '0;
  logic [LW-1:0] cfg_wgt_len = '0;
  logic [LW-1:0] cfg_bias_len = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    sel;
  logic [DW-1:0] out_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  buffer_load_sequencer #(
    .DATA_WIDTH (DW),
    .ADDR_W     (AW),
    .LEN_W      (LW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_ifm_len  (cfg_ifm_len),
    .cfg_wgt_len  (cfg_wgt_len),
    .cfg_bias_len (cfg_bias_len),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sel          (sel),
    .out_data     (out_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int li;
    int lw;
    int lb;
    int vmode;     // 0: valid always, 1: toggling 1010, 2: random
    bit restart;   // pulse start again during the weight phase
    int abort_at;  // nonzero: pull reset once this many words were accepted
    int exp_wr;    // writes expected to be observed
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 0);
    chk({tag, " sel"}, 32'(sel), 0);
    chk({tag, " out_data"}, out_data, 0);
    chk({tag, " wr_en"}, 32'(wr_en), 0);
    chk({tag, " wr_addr"}, 32'(wr_addr), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
  endtask

  // Word k of a load lands in the k-th slot of the concatenated IFM/WGT/BIAS bursts.
  function automatic void target_of(input int k, input int li, input int lw,
                                    output logic [1:0] s, output int a);
    if (k < li) begin
      s = SEL_IFM;  a = k;
    end else if (k < li + lw) begin
      s = SEL_WGT;  a = k - li;
    end else begin
      s = SEL_BIAS; a = k - li - lw;
    end
  endfunction

  task automatic run_load(input vec_t v, output int nwr);
    logic [DW-1:0] words[$];
    int total, acc, wr_idx, last_acc_c, done_c, budget;
    bit pend, fin, aborted, restarted, vld, exp_rdy, exp_busy;
    logic [1:0] last_sel, es;
    int ea;

    total = v.li + v.lw + v.lb;
    budget = 4 * total + 20;
    acc = 0; wr_idx = 0; nwr = 0; last_acc_c = -10;
    done_c = (total == 0) ? 1 : -1;
    pend = 0; fin = 0; aborted = 0; restarted = 0;
    last_sel = SEL_NONE;

    @(negedge clk);
    start = 1'b1;
    cfg_ifm_len = LW'(v.li);
    cfg_wgt_len = LW'(v.lw);
    cfg_bias_len = LW'(v.lb);
    in_valid = 1'b0;

    for (int c = 1; c <= budget && !fin; c++) begin
      @(negedge clk);
      start = 1'b0;
      cfg_ifm_len = LW'($urandom_range(0, 8));
      cfg_wgt_len = LW'($urandom_range(0, 8));
      cfg_bias_len = LW'($urandom_range(0, 8));

      exp_rdy = (acc < total);
      exp_busy = (total > 0) && ((acc < total) || (c == last_acc_c + 1));
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(c == done_c));
      chk("wr_en", 32'(wr_en), 32'(pend));
      if (pend) begin
        target_of(wr_idx, v.li, v.lw, es, ea);
        chk("wr sel", 32'(sel), 32'(es));
        chk("wr addr", 32'(wr_addr), ea);
        chk("wr data", out_data, words[wr_idx]);
        last_sel = es;
        wr_idx++;
        nwr++;
      end else begin
        chk("sel hold", 32'(sel), 32'(last_sel));
      end

      if (c == done_c) begin
        fin = 1;
      end else if (v.abort_at != 0 && acc == v.abort_at) begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_all_zero("abort");
        repeat (2) begin
          @(negedge clk);
          chk("abort no done", 32'(done), 0);
          chk("abort busy", 32'(busy), 0);
        end
        rst_n = 1'b1;
        fin = 1;
        aborted = 1;
      end else begin
        unique case (v.vmode)
          0:       vld = 1'b1;
          1:       vld = ((c % 2) == 1);
          default: vld = ($urandom_range(0, 9) < 7);
        endcase
        in_valid = vld;
        in_data = $urandom;
        pend = vld && exp_rdy;
        if (pend) begin
          words.push_back(in_data);
          acc++;
          if (acc == total) begin
            last_acc_c = c;
            done_c = c + 2;
          end
        end
        if (v.restart && !restarted && acc == v.li + 2 && acc < total) begin
          start = 1'b1;
          restarted = 1;
        end
      end
    end

    in_valid = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for done, accepted=%0d of %0d", acc, total);
    end else if (!aborted) begin
      @(negedge clk);
      chk("idle sel", 32'(sel), 32'(SEL_NONE));
      chk("idle busy", 32'(busy), 0);
      chk("idle done", 32'(done), 0);
      chk("idle in_ready", 32'(in_ready), 0);
      chk("idle wr_en", 32'(wr_en), 0);
    end
  endtask

  vec_t vecs [10];

  initial begin
    int nwr;
    vec_t rv;

    vecs[0] = '{li: 4,    lw: 3, lb: 2, vmode: 0, restart: 0, abort_at: 0, exp_wr: 9};
    vecs[1] = '{li: 0,    lw: 5, lb: 0, vmode: 0, restart: 0, abort_at: 0, exp_wr: 5};
    vecs[2] = '{li: 0,    lw: 0, lb: 0, vmode: 0, restart: 0, abort_at: 0, exp_wr: 0};
    vecs[3] = '{li: 3,    lw: 3, lb: 3, vmode: 1, restart: 0, abort_at: 0, exp_wr: 9};
    vecs[4] = '{li: 4,    lw: 5, lb: 2, vmode: 0, restart: 1, abort_at: 0, exp_wr: 11};
    vecs[5] = '{li: 3,    lw: 3, lb: 3, vmode: 0, restart: 0, abort_at: 7, exp_wr: 7};
    vecs[6] = '{li: 1,    lw: 1, lb: 1, vmode: 0, restart: 0, abort_at: 0, exp_wr: 3};
    vecs[7] = '{li: 1,    lw: 0, lb: 0, vmode: 2, restart: 0, abort_at: 0, exp_wr: 1};
    vecs[8] = '{li: 0,    lw: 0, lb: 1, vmode: 2, restart: 0, abort_at: 0, exp_wr: 1};
    vecs[9] = '{li: 1024, lw: 0, lb: 2, vmode: 0, restart: 0, abort_at: 0, exp_wr: 1026};

    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_load(vecs[i], nwr);
      chk($sformatf("vec%0d write count", i), nwr, vecs[i].exp_wr);
    end

    for (int i = 0; i < 20; i++) begin
      rv.li = $urandom_range(0, 6);
      rv.lw = $urandom_range(0, 6);
      rv.lb = $urandom_range(0, 6);
      rv.vmode = $urandom_range(0, 2);
      rv.restart = 1'($urandom_range(0, 1));
      rv.abort_at = 0;
      rv.exp_wr = rv.li + rv.lw + rv.lb;
      run_load(rv, nwr);
      chk($sformatf("rand%0d write count", i), nwr, rv.exp_wr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
